// File: rtl/pheap_level_store.sv
// Storage for one level of the pipelined heap: true dual-port array with a
// hardware init sweep, selectable cross-port collision behaviour and an
// optional second output register stage.
module pheap_level_store #(
  parameter int                  LEVEL       = 2,
  parameter int                  ENTRY_W     = 32,
  parameter logic [ENTRY_W-1:0]  INIT_VAL    = '0,
  parameter bit                  OUT_REG     = 1'b0,
  parameter bit                  WRITE_FIRST = 1'b0,
  localparam int                 DEPTH       = 2 ** (LEVEL - 1),
  localparam int                 AW          = (LEVEL > 1) ? LEVEL - 1 : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  output logic               ready,
  input  logic               req_a,
  input  logic               we_a,
  input  logic [AW-1:0]      addr_a,
  input  logic [ENTRY_W-1:0] wdata_a,
  output logic [ENTRY_W-1:0] rdata_a,
  output logic               rvalid_a,
  input  logic               req_b,
  input  logic               we_b,
  input  logic [AW-1:0]      addr_b,
  input  logic [ENTRY_W-1:0] wdata_b,
  output logic [ENTRY_W-1:0] rdata_b,
  output logic               rvalid_b,
  output logic               coll
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [AW-1:0]      idx_a, idx_b;
  logic               is_ready, same_addr;
  logic               rd_a, rd_b, wr_a, wr_b, wr_b_eff;
  logic               mem_we_a;
  logic [AW-1:0]      mem_idx_a;
  logic [ENTRY_W-1:0] mem_din_a;
  logic [ENTRY_W-1:0] rd_data_a, rd_data_b;

  logic [ENTRY_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic               rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic               coll_q, coll_d;

  // A single-entry level has only one location, so the address is ignored.
  if (LEVEL == 1) begin : g_idx_single
    assign idx_a = '0;
    assign idx_b = '0;
  end else begin : g_idx_full
    assign idx_a = addr_a;
    assign idx_b = addr_b;
  end

  assign is_ready = (state_q == ST_READY);

  // Request decode, write arbitration, init-sweep muxing and next-state logic.
  always_comb begin
    rd_a      = is_ready & req_a & ~we_a;
    rd_b      = is_ready & req_b & ~we_b;
    wr_a      = is_ready & req_a & we_a;
    wr_b      = is_ready & req_b & we_b;
    same_addr = (idx_a == idx_b);
    // Port A wins a same-address double write.
    wr_b_eff  = wr_b & ~(wr_a & same_addr);

    // The init sweep borrows port A's write path.
    mem_we_a  = ~is_ready | wr_a;
    mem_idx_a = is_ready ? idx_a : cnt_q;
    mem_din_a = is_ready ? wdata_a : INIT_VAL;

    rd_data_a = mem[idx_a];
    rd_data_b = mem[idx_b];
    if (WRITE_FIRST && wr_b && same_addr) rd_data_a = wdata_b;
    if (WRITE_FIRST && wr_a && same_addr) rd_data_b = wdata_a;

    // Read data holds its last value across writes and idle cycles.
    rdata_a_d  = rd_a ? rd_data_a : rdata_a_q;
    rdata_b_d  = rd_b ? rd_data_b : rdata_b_q;
    rvalid_a_d = rd_a;
    rvalid_b_d = rd_b;
    coll_d     = wr_a & wr_b & same_addr;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Array write ports; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_a) mem[mem_idx_a] <= mem_din_a;
    if (wr_b_eff) mem[idx_b]     <= wdata_b;
  end

  // FSM, sweep counter and first read-data stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      coll_q     <= coll_d;
    end
  end

  assign ready = is_ready;
  assign coll  = coll_q;

  if (OUT_REG) begin : g_oreg
    logic [ENTRY_W-1:0] o_rdata_a_q, o_rdata_a_d, o_rdata_b_q, o_rdata_b_d;
    logic               o_rvalid_a_q, o_rvalid_b_q;

    // Second stage only captures genuine read results.
    always_comb begin
      o_rdata_a_d = rvalid_a_q ? rdata_a_q : o_rdata_a_q;
      o_rdata_b_d = rvalid_b_q ? rdata_b_q : o_rdata_b_q;
    end

    // Extra output register stage (read latency 2).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_rdata_a_q  <= '0;
        o_rdata_b_q  <= '0;
        o_rvalid_a_q <= 1'b0;
        o_rvalid_b_q <= 1'b0;
      end else begin
        o_rdata_a_q  <= o_rdata_a_d;
        o_rdata_b_q  <= o_rdata_b_d;
        o_rvalid_a_q <= rvalid_a_q;
        o_rvalid_b_q <= rvalid_b_q;
      end
    end

    assign rdata_a  = o_rdata_a_q;
    assign rdata_b  = o_rdata_b_q;
    assign rvalid_a = o_rvalid_a_q;
    assign rvalid_b = o_rvalid_b_q;
  end else begin : g_noreg
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
  end

endmodule

// File: tb/tb_pheap_level_store.sv
// Directed bench: two LEVEL=3 instances share all inputs.
// u0: OUT_REG=0, WRITE_FIRST=0 (latency 1); u1: OUT_REG=1, WRITE_FIRST=1 (latency 2).
module tb_pheap_level_store;

  localparam int          W  = 32;
  localparam logic [W-1:0] IV = 32'hA5A5_0000;

  logic         clk, rst_n, clear;
  logic         req_a, we_a, req_b, we_b;
  logic [1:0]   addr_a, addr_b;
  logic [W-1:0] wdata_a, wdata_b;

  logic         rdy0, rva0, rvb0, col0;
  logic [W-1:0] rda0, rdb0;
  logic         rdy1, rva1, rvb1, col1;
  logic [W-1:0] rda1, rdb1;

  int n_cmp = 0;
  int n_bad = 0;

  pheap_level_store #(.LEVEL(3), .ENTRY_W(W), .INIT_VAL(IV), .OUT_REG(1'b0), .WRITE_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(rdy0),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rda0), .rvalid_a(rva0),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rdb0), .rvalid_b(rvb0),
    .coll(col0));

  pheap_level_store #(.LEVEL(3), .ENTRY_W(W), .INIT_VAL(IV), .OUT_REG(1'b1), .WRITE_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(rdy1),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .rdata_a(rda1), .rvalid_a(rva1),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .rdata_b(rdb1), .rvalid_b(rvb1),
    .coll(col1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; prints the transaction presented at that edge.
  task automatic tick();
    if (req_a || req_b || clear)
      $display("t=%0t clr=%0b A:req=%0b we=%0b addr=%0d d=%h B:req=%0b we=%0b addr=%0d d=%h",
               $time, clear, req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b);
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic rq, input logic we, input logic [1:0] ad, input logic [W-1:0] d);
    req_a = rq; we_a = we; addr_a = ad; wdata_a = d;
  endtask

  task automatic set_b(input logic rq, input logic we, input logic [1:0] ad, input logic [W-1:0] d);
    req_b = rq; we_b = we; addr_b = ad; wdata_b = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 2'd0, '0);
    set_b(1'b0, 1'b0, 2'd0, '0);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    n_cmp++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b/%b want 0/0", rdy0, rdy1); end
    n_cmp++; if ({rva0, rvb0, rva1, rvb1} !== 4'b0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0000", {rva0, rvb0, rva1, rvb1}); end
    n_cmp++; if (rda0 !== '0 || rdb1 !== '0) begin n_bad++; $display("FAIL reset_rdata got %h/%h want 0/0", rda0, rdb1); end
    n_cmp++; if (col0 !== 1'b0 || col1 !== 1'b0) begin n_bad++; $display("FAIL reset_coll got %b/%b want 0/0", col0, col1); end
    // Reads during the sweep must be ignored.
    set_a(1'b1, 1'b0, 2'd0, '0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (rdy0 !== (k == 4) || rdy1 !== (k == 4)) begin n_bad++; $display("FAIL init_ready k=%0d got %b/%b want %b", k, rdy0, rdy1, (k == 4)); end
      n_cmp++; if (rva0 !== 1'b0) begin n_bad++; $display("FAIL init_ignore_rd k=%0d rvalid_a got %b want 0", k, rva0); end
    end
    idle();
  endtask

  task automatic test_init_read();
    for (int a = 0; a < 4; a++) begin
      set_a(1'b1, 1'b0, 2'(a), '0);
      tick();
      n_cmp++; if (rda0 !== IV || rva0 !== 1'b1) begin n_bad++; $display("FAIL init_rd_u0 addr=%0d got %h/%b want %h/1", a, rda0, rva0, IV); end
      n_cmp++; if (rva1 !== 1'b0) begin n_bad++; $display("FAIL init_rd_u1_early addr=%0d rvalid got %b want 0", a, rva1); end
      idle();
      tick();
      n_cmp++; if (rda1 !== IV || rva1 !== 1'b1 || rva0 !== 1'b0) begin n_bad++; $display("FAIL init_rd_u1 addr=%0d got %h/%b u0rv=%b want %h/1/0", a, rda1, rva1, rva0, IV); end
    end
  endtask

  task automatic test_write_read();
    set_a(1'b1, 1'b1, 2'd2, 32'hDEAD);
    tick();
    n_cmp++; if (rva0 !== 1'b0 || rva1 !== 1'b0) begin n_bad++; $display("FAIL wr_no_rvalid got %b/%b want 0/0", rva0, rva1); end
    idle();
    set_b(1'b1, 1'b0, 2'd2, '0);
    tick();
    n_cmp++; if (rdb0 !== 32'hDEAD || rvb0 !== 1'b1) begin n_bad++; $display("FAIL wr_rd_lat1 got %h/%b want 0000dead/1", rdb0, rvb0); end
    n_cmp++; if (rvb1 !== 1'b0) begin n_bad++; $display("FAIL wr_rd_lat2_early rvalid got %b want 0", rvb1); end
    idle();
    tick();
    n_cmp++; if (rdb1 !== 32'hDEAD || rvb1 !== 1'b1) begin n_bad++; $display("FAIL wr_rd_lat2 got %h/%b want 0000dead/1", rdb1, rvb1); end
  endtask

  task automatic test_collision();
    set_a(1'b1, 1'b1, 2'd1, 32'h11);
    set_b(1'b1, 1'b1, 2'd1, 32'h22);
    tick();
    n_cmp++; if (col0 !== 1'b1 || col1 !== 1'b1) begin n_bad++; $display("FAIL coll_pulse got %b/%b want 1/1", col0, col1); end
    set_a(1'b1, 1'b1, 2'd0, 32'hA0);
    set_b(1'b1, 1'b1, 2'd3, 32'hB3);
    tick();
    n_cmp++; if (col0 !== 1'b0 || col1 !== 1'b0) begin n_bad++; $display("FAIL coll_diff_addr got %b/%b want 0/0", col0, col1); end
    set_a(1'b1, 1'b0, 2'd1, '0);
    idle();
    set_a(1'b1, 1'b0, 2'd1, '0);
    tick();
    n_cmp++; if (rda0 !== 32'h11) begin n_bad++; $display("FAIL coll_port_a_wins u0 got %h want 00000011", rda0); end
    idle();
    tick();
    n_cmp++; if (rda1 !== 32'h11) begin n_bad++; $display("FAIL coll_port_a_wins u1 got %h want 00000011", rda1); end
    set_b(1'b1, 1'b0, 2'd3, '0);
    tick();
    n_cmp++; if (rdb0 !== 32'hB3) begin n_bad++; $display("FAIL diff_addr_b_write got %h want 000000b3", rdb0); end
    idle();
    tick();
  endtask

  task automatic test_write_first();
    set_a(1'b1, 1'b1, 2'd0, 32'h5);
    tick();
    set_a(1'b1, 1'b1, 2'd0, 32'h7);
    set_b(1'b1, 1'b0, 2'd0, '0);
    tick();
    n_cmp++; if (rdb0 !== 32'h5 || rvb0 !== 1'b1) begin n_bad++; $display("FAIL read_first got %h/%b want 00000005/1", rdb0, rvb0); end
    idle();
    tick();
    n_cmp++; if (rdb1 !== 32'h7 || rvb1 !== 1'b1) begin n_bad++; $display("FAIL write_first got %h/%b want 00000007/1", rdb1, rvb1); end
    set_a(1'b1, 1'b0, 2'd0, '0);
    set_b(1'b1, 1'b0, 2'd0, '0);
    tick();
    n_cmp++; if (rda0 !== 32'h7 || rdb0 !== 32'h7) begin n_bad++; $display("FAIL dual_read_u0 got %h/%h want 7/7", rda0, rdb0); end
    idle();
    tick();
    n_cmp++; if (rda1 !== 32'h7 || rdb1 !== 32'h7) begin n_bad++; $display("FAIL dual_read_u1 got %h/%h want 7/7", rda1, rdb1); end
  endtask

  task automatic test_no_change();
    set_a(1'b1, 1'b1, 2'd3, 32'h3);
    tick();
    set_a(1'b1, 1'b0, 2'd3, '0);
    tick();
    n_cmp++; if (rda0 !== 32'h3 || rva0 !== 1'b1) begin n_bad++; $display("FAIL nochg_read got %h/%b want 3/1", rda0, rva0); end
    set_a(1'b1, 1'b1, 2'd1, 32'h99);
    tick();
    n_cmp++; if (rda0 !== 32'h3 || rva0 !== 1'b0) begin n_bad++; $display("FAIL nochg_write_u0 got %h/%b want 3/0", rda0, rva0); end
    n_cmp++; if (rda1 !== 32'h3 || rva1 !== 1'b1) begin n_bad++; $display("FAIL nochg_inflight_u1 got %h/%b want 3/1", rda1, rva1); end
    idle();
    tick();
    n_cmp++; if (rda1 !== 32'h3 || rva1 !== 1'b0) begin n_bad++; $display("FAIL nochg_hold_u1 got %h/%b want 3/0", rda1, rva1); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_v [4];
    exp_v[0] = 32'h7; exp_v[1] = 32'h99; exp_v[2] = 32'hDEAD; exp_v[3] = 32'h3;
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 1'b0, 2'(i), '0);
      tick();
      n_cmp++; if (rda0 !== exp_v[i] || rva0 !== 1'b1) begin n_bad++; $display("FAIL b2b_u0 i=%0d got %h/%b want %h/1", i, rda0, rva0, exp_v[i]); end
      if (i > 0) begin
        n_cmp++; if (rda1 !== exp_v[i-1] || rva1 !== 1'b1) begin n_bad++; $display("FAIL b2b_u1 i=%0d got %h/%b want %h/1", i, rda1, rva1, exp_v[i-1]); end
      end
    end
    idle();
    tick();
    n_cmp++; if (rda1 !== exp_v[3] || rva1 !== 1'b1 || rva0 !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got %h/%b u0rv=%b want %h/1/0", rda1, rva1, rva0, exp_v[3]); end
  endtask

  task automatic test_clear();
    set_a(1'b1, 1'b0, 2'd2, '0);
    clear = 1'b1;
    tick();
    n_cmp++; if (rda0 !== 32'hDEAD || rva0 !== 1'b1 || rdy0 !== 1'b0) begin n_bad++; $display("FAIL clear_read got %h/%b rdy=%b want 0000dead/1/0", rda0, rva0, rdy0); end
    clear = 1'b0;
    set_a(1'b1, 1'b0, 2'd0, '0);
    set_b(1'b1, 1'b1, 2'd2, 32'hBAD);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (rva0 !== 1'b0 || rda0 !== 32'hDEAD) begin n_bad++; $display("FAIL clear_ignore k=%0d got %h/%b want 0000dead/0", k, rda0, rva0); end
      n_cmp++; if (rva1 !== (k == 1) || rda1 !== 32'hDEAD) begin n_bad++; $display("FAIL clear_inflight k=%0d got %h/%b want 0000dead/%b", k, rda1, rva1, (k == 1)); end
      n_cmp++; if (rdy0 !== (k == 4)) begin n_bad++; $display("FAIL clear_ready k=%0d got %b want %b", k, rdy0, (k == 4)); end
    end
    idle();
    for (int a = 0; a < 4; a++) begin
      set_a(1'b1, 1'b0, 2'(a), '0);
      set_b(1'b1, 1'b0, 2'(a), '0);
      tick();
      n_cmp++; if (rda0 !== IV || rdb0 !== IV) begin n_bad++; $display("FAIL clear_swept addr=%0d got %h/%h want %h", a, rda0, rdb0, IV); end
    end
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rdy0 !== 1'b0 || rda0 !== '0 || rdb0 !== '0 || rda1 !== '0) begin n_bad++; $display("FAIL arst_immediate got rdy=%b %h %h %h want 0 and zeros", rdy0, rda0, rdb0, rda1); end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (rdy0 !== (k == 4) || rdy1 !== (k == 4)) begin n_bad++; $display("FAIL arst_restart k=%0d got %b/%b want %b", k, rdy0, rdy1, (k == 4)); end
    end
    // A read still inside u1's pipeline must be killed by reset.
    set_a(1'b1, 1'b0, 2'd1, '0);
    tick();
    n_cmp++; if (rva0 !== 1'b1 || rda0 !== IV) begin n_bad++; $display("FAIL kill_setup got %h/%b want %h/1", rda0, rva0, IV); end
    idle();
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (rva1 !== 1'b0 || rda1 !== '0) begin n_bad++; $display("FAIL kill_inflight k=%0d got %h/%b want 0/0", k, rda1, rva1); end
    end
    n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL kill_ready got %b want 1", rdy1); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_write_read();
    test_collision();
    test_write_first();
    test_no_change();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
